// File: rtl/clock_input_counter_pkg.sv
// Shared constants for the clocks test suite: FSM state encodings and
// width limits used by the clock-input counter and its core.
package clock_input_counter_pkg;

    // 2-bit state encoding; the unused value 3 is treated as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Smallest meaningful counter width.
    localparam int MIN_WIDTH = 2;

    // Default counter / limit width.
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/clock_input_counter_core.sv
// Counter datapath: WIDTH-bit register with synchronous clear,
// increment enable and an equality compare against the latched limit.
module clock_input_counter_core
    import clock_input_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register: clear wins over increment, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    // Terminal compare against the limit captured at start.
    always_comb begin
        at_limit = (count == cmp_val);
    end

endmodule

// File: rtl/clock_input_counter.sv
// Clock-input counter: counts enabled cycles of a clock-attributed input
// up to a programmable limit, pulses tc at terminal count, then either
// stops in DONE or reloads and keeps running.
(* whitebox *)
module clock_input_counter
    import clock_input_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    (* CLOCK *)
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_e           state_q;
    state_e           next_state;
    logic [WIDTH-1:0] limit_q;
    logic             ld_limit;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             at_limit;
    logic             tc_d;
    logic             busy_d;

    clock_input_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cmp_val  (limit_q),
        .count    (count),
        .at_limit (at_limit)
    );

    // State, limit and output flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= next_state;
            tc      <= tc_d;
            busy    <= busy_d;
            if (ld_limit) begin
                limit_q <= limit;
            end
        end
    end

    // Next-state and datapath control; an illegal encoding behaves as IDLE.
    always_comb begin
        next_state = ST_IDLE;
        ld_limit   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        tc_d       = 1'b0;

        case (state_q)
            ST_RUN: begin
                next_state = ST_RUN;
                if (en) begin
                    if (at_limit) begin
                        tc_d = 1'b1;
                        if (reload) begin
                            cnt_clr = 1'b1;
                        end else begin
                            next_state = ST_DONE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                next_state = ST_DONE;
                if (start) begin
                    ld_limit = 1'b1;
                    cnt_clr  = 1'b1;
                    if (limit == '0) begin
                        tc_d = 1'b1;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                if (start) begin
                    ld_limit = 1'b1;
                    cnt_clr  = 1'b1;
                    // A zero limit is already terminal: skip RUN entirely.
                    if (limit == '0) begin
                        next_state = ST_DONE;
                        tc_d       = 1'b1;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
            end
        endcase

        busy_d = (next_state == ST_RUN);
    end

endmodule

// File: tb/tb_clock_input_counter.sv
// Directed bench for clock_input_counter (WIDTH=8): a vector table for
// the cycle-by-cycle behaviour plus hand sequences for async reset and
// the full-range limit.
module tb_clock_input_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         en;
    logic         reload;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int checks;
    int errors;

    typedef struct packed {
        logic         start;
        logic         en;
        logic         reload;
        logic [W-1:0] limit;
        logic [W-1:0] exp_count;
        logic         exp_tc;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    clock_input_counter #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .en     (en),
        .reload (reload),
        .limit  (limit),
        .count  (count),
        .tc     (tc),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] ec,
                         input logic et, input logic eb);
        checks++;
        if (count !== ec || tc !== et || busy !== eb) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b, want count=%0d tc=%0b busy=%0b",
                     name, count, tc, busy, ec, et, eb);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic e, input logic r, input int l,
                       input int ec, input logic et, input logic eb);
        vecs.push_back(vec_t'{s, e, r, W'(l), W'(ec), et, eb});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        en     = 1'b0;
        reload = 1'b0;
        limit  = '0;

        // Single-shot, limit 3
        add(1, 1, 0, 3, 0, 0, 1);
        add(0, 1, 0, 3, 1, 0, 1);
        add(0, 1, 0, 3, 2, 0, 1);
        add(0, 1, 0, 3, 3, 0, 1);
        add(0, 1, 0, 3, 3, 1, 0);
        add(0, 1, 0, 3, 3, 0, 0);
        // Auto-reload, limit 2, started from DONE
        add(1, 1, 1, 2, 0, 0, 1);
        add(0, 1, 1, 2, 1, 0, 1);
        add(0, 1, 1, 2, 2, 0, 1);
        add(0, 1, 1, 2, 0, 1, 1);
        add(0, 1, 1, 2, 1, 0, 1);
        add(0, 1, 1, 2, 2, 0, 1);
        add(0, 1, 1, 2, 0, 1, 1);
        add(0, 1, 1, 2, 1, 0, 1);
        add(0, 1, 1, 2, 2, 0, 1);
        add(0, 1, 0, 2, 2, 1, 0);
        // Enable gaps, mid-run start / limit ignored, limit 4
        add(1, 0, 0, 4, 0, 0, 1);
        add(0, 1, 0, 4, 1, 0, 1);
        add(1, 0, 0, 1, 1, 0, 1);
        add(0, 1, 0, 1, 2, 0, 1);
        add(0, 0, 0, 4, 2, 0, 1);
        add(1, 1, 0, 1, 3, 0, 1);
        add(0, 0, 0, 4, 3, 0, 1);
        add(0, 1, 0, 4, 4, 0, 1);
        add(0, 0, 0, 4, 4, 0, 1);
        add(0, 1, 0, 4, 4, 1, 0);
        add(0, 1, 0, 4, 4, 0, 0);
        // Zero limit goes straight to DONE with one tc pulse
        add(1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0);

        // Reset state, before any clock edge and while held
        #1;
        check("reset_async", 0, 0, 0);
        step();
        check("reset_held", 0, 0, 0);
        rst = 1'b0;
        step();
        check("idle_no_start", 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            start  = vecs[i].start;
            en     = vecs[i].en;
            reload = vecs[i].reload;
            limit  = vecs[i].limit;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_busy);
        end

        // Reset mid-run clears outputs without a clock edge
        start = 1'b1; en = 1'b1; reload = 1'b0; limit = 8'd5;
        step();
        check("midrun_start", 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("midrun_before_rst", 3, 0, 1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_async", 0, 0, 0);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_idle", 0, 0, 0);

        // Full-range limit: 256 enabled cycles to tc, no wrap
        start = 1'b1; en = 1'b1; reload = 1'b0; limit = 8'd255;
        step();
        start = 1'b0;
        check("max_start", 0, 0, 1);
        begin
            int bad;
            bad = 0;
            for (int i = 1; i <= 255; i++) begin
                step();
                if (count !== W'(i) || tc !== 1'b0 || busy !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL max_ramp: got %0d bad cycles, want 0", bad);
            end
        end
        check("max_at_limit", 255, 0, 1);
        step();
        check("max_tc", 255, 1, 0);
        step();
        check("max_hold", 255, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
